// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone-slave GPIO port, the successor to the fixed 16-bit I/O slave.
// It adds per-pin direction, a synchronised input path, rising/falling edge
// capture into a W1C STATUS register, and a maskable level interrupt.
//
// Optional feature: define WB_GPIO_ATOMIC_EN to add the write-only SET (7),
// CLR (8) and TGL (9) aliases of OUT. When it is undefined, those addresses
// behave as unmapped and no logic is added.
//
// Bus timing: a request is cyc & stb & ~ack. Ack is registered and is a single
// pulse, so a master that holds stb high gets one access every two cycles.
module wb_gpio #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [15:0]      wb_dat_i,
    output logic [15:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    // Word addresses inside the I/O window.
    typedef enum logic [3:0] {
        ADR_OUT     = 4'd0,
        ADR_IN      = 4'd1,
        ADR_DIR     = 4'd2,
        ADR_RISE_EN = 4'd3,
        ADR_FALL_EN = 4'd4,
        ADR_STATUS  = 4'd5,
        ADR_MASK    = 4'd6,
        ADR_SET     = 4'd7,
        ADR_CLR     = 4'd8,
        ADR_TGL     = 4'd9
    } reg_addr_e;

    // Register bits above WIDTH read back as zero.
    function automatic logic [15:0] zext(input logic [WIDTH-1:0] v);
        logic [15:0] r;
        r           = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Control/status registers.
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_mask;

    // Input synchroniser and edge history.
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Decoded bus request and datapath wires.
    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdat;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_status_next;
    logic [WIDTH-1:0] w_out_next;
    logic [15:0]      w_rdata;

    // Ack in flight blocks a second request, which gives the 1-of-2 throughput.
    assign w_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_wr     = w_req & wb_we_i;
    assign w_rd     = w_req & ~wb_we_i;
    assign w_wdat   = wb_dat_i[WIDTH-1:0];
    assign w_sync_q = r_sync[SYNC_STAGES-1];

    assign gpio_o  = r_out;
    assign gpio_oe = r_dir;

    // Edge detection and STATUS next-state; a fresh edge overrides a W1C of the same bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_rise        = w_sync_q & ~r_prev & r_rise_en;
        w_fall        = ~w_sync_q & r_prev & r_fall_en;
        w_w1c         = '0;
        if (w_wr && (wb_adr_i == ADR_STATUS)) begin
            w_w1c = w_wdat;
        end
        w_status_next = (r_status & ~w_w1c) | w_rise | w_fall;
    end

    // Next OUT value: plain write, or the atomic aliases when enabled.
    always_comb begin
        w_out_next = r_out;
        if (w_wr) begin
            case (wb_adr_i)
                ADR_OUT: w_out_next = w_wdat;
`ifdef WB_GPIO_ATOMIC_EN
                ADR_SET: w_out_next = r_out | w_wdat;
                ADR_CLR: w_out_next = r_out & ~w_wdat;
                ADR_TGL: w_out_next = r_out ^ w_wdat;
`endif
                default: w_out_next = r_out;
            endcase
        end
    end

    // Read multiplexer; unmapped and write-only addresses read zero.
    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            ADR_OUT:     w_rdata = zext(r_out);
            ADR_IN:      w_rdata = zext(w_sync_q);
            ADR_DIR:     w_rdata = zext(r_dir);
            ADR_RISE_EN: w_rdata = zext(r_rise_en);
            ADR_FALL_EN: w_rdata = zext(r_fall_en);
            ADR_STATUS:  w_rdata = zext(r_status);
            ADR_MASK:    w_rdata = zext(r_mask);
            default:     w_rdata = '0;
        endcase
    end

    // Pad synchroniser chain and one-cycle edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the synchroniser is a handful of flops, not a RAM, so resetting it is cheap and keeps IN defined after reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_q;
        end
    end

    // Control/status register file; writes land on the edge that raises ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_mask    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_out    <= w_out_next;
            r_status <= w_status_next;
            if (w_wr) begin
                case (wb_adr_i)
                    ADR_DIR:     r_dir     <= w_wdat;
                    ADR_RISE_EN: r_rise_en <= w_wdat;
                    ADR_FALL_EN: r_fall_en <= w_wdat;
                    ADR_MASK:    r_mask    <= w_wdat;
                    default:     ;
                endcase
            end
        end
    end

    // Bus response and interrupt; read data holds until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= w_req;
            if (w_rd) begin
                wb_dat_o <= w_rdata;
            end
            irq_o <= |(w_status_next & r_mask);
        end
    end

endmodule

// File: tb/tb_wb_gpio.sv
// tb_wb_gpio: directed test of wb_gpio with a register-array reference model
// compared against every DUT output on each falling clock edge.
module tb_wb_gpio;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic [15:0] gpio_i = '0;
    logic [15:0] gpio_o;
    logic [15:0] gpio_oe;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    wb_gpio #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_reg holds the architected register contents indexed by word address;
    // m_hist[k] is the pad value sampled k+1 edges ago, so the synchronised
    // value is the sample SYNC edges old and the edge history one older.
    logic [15:0] m_reg  [16];
    logic [15:0] m_hist [SYNC+1];
    logic        m_ack;
    logic [15:0] m_dat;
    logic        m_irq;

    logic        mn_req;
    logic [15:0] mn_sync;
    logic [15:0] mn_prev;
    logic [15:0] mn_w1c;
    logic [15:0] mn_status;
    logic [15:0] mn_out;
    logic [15:0] mn_rdata;

    always_comb begin
        mn_sync   = m_hist[SYNC-1];
        mn_prev   = m_hist[SYNC];
        mn_req    = wb_cyc_i & wb_stb_i & ~m_ack;
        mn_w1c    = (mn_req && wb_we_i && wb_adr_i == 4'd5) ? wb_dat_i : 16'h0;
        mn_status = (m_reg[5] & ~mn_w1c)
                  | (mn_sync & ~mn_prev & m_reg[3])
                  | (~mn_sync & mn_prev & m_reg[4]);
        mn_out    = m_reg[0];
        if (mn_req && wb_we_i) begin
            if (wb_adr_i == 4'd0) mn_out = wb_dat_i;
`ifdef WB_GPIO_ATOMIC_EN
            if (wb_adr_i == 4'd7) mn_out = m_reg[0] | wb_dat_i;
            if (wb_adr_i == 4'd8) mn_out = m_reg[0] & ~wb_dat_i;
            if (wb_adr_i == 4'd9) mn_out = m_reg[0] ^ wb_dat_i;
`endif
        end
        mn_rdata = 16'h0;
        if (wb_adr_i == 4'd1) mn_rdata = mn_sync;
        else if (wb_adr_i == 4'd0 || (wb_adr_i >= 4'd2 && wb_adr_i <= 4'd6)) mn_rdata = m_reg[wb_adr_i];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_reg[i] <= 16'h0;
            for (int i = 0; i <= SYNC; i++) m_hist[i] <= 16'h0;
            m_ack <= 1'b0;
            m_dat <= 16'h0;
            m_irq <= 1'b0;
        end else begin
            m_ack <= mn_req;
            if (mn_req && !wb_we_i) m_dat <= mn_rdata;
            m_irq    <= |(mn_status & m_reg[6]);
            m_reg[0] <= mn_out;
            m_reg[5] <= mn_status;
            if (mn_req && wb_we_i && (wb_adr_i inside {4'd2, 4'd3, 4'd4, 4'd6}))
                m_reg[wb_adr_i] <= wb_dat_i;
            m_hist[0] <= gpio_i;
            for (int i = 1; i <= SYNC; i++) m_hist[i] <= m_hist[i-1];
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("ack",     {31'b0, wb_ack_o}, {31'b0, m_ack});
            check("dat_o",   {16'b0, wb_dat_o}, {16'b0, m_dat});
            check("gpio_o",  {16'b0, gpio_o},   {16'b0, m_reg[0]});
            check("gpio_oe", {16'b0, gpio_oe},  {16'b0, m_reg[2]});
            check("irq",     {31'b0, irq_o},    {31'b0, m_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    // All stimulus is applied 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                           output logic [15:0] rdat);
        bit got;
        got      = 1'b0;
        lat      = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        rdat     = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) check("ack_timeout", {31'b0, wb_ack_o}, 32'h1);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [15:0] dat);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, dat, dummy);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [15:0] dat);
        wb_xfer(1'b0, adr, 16'h0, dat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] rd;
        int          acks;

        // Reset values.
        tick(2);
        check("rst_ack",     {31'b0, wb_ack_o}, 32'h0);
        check("rst_dat",     {16'b0, wb_dat_o}, 32'h0);
        check("rst_gpio_o",  {16'b0, gpio_o},   32'h0);
        check("rst_gpio_oe", {16'b0, gpio_oe},  32'h0);
        check("rst_irq",     {31'b0, irq_o},    32'h0);
        rst = 1'b0;
        tick(1);

        // Write and read back OUT/DIR; ack one cycle after the request, single pulse.
        wb_write(4'd0, 16'hA5A5);
        check("ack_latency", lat, 32'd1);
        check("out_after_wr", {16'b0, gpio_o}, 32'hA5A5);
        tick(1);
        check("ack_pulse", {31'b0, wb_ack_o}, 32'h0);
        wb_write(4'd2, 16'h00FF);
        check("dir_after_wr", {16'b0, gpio_oe}, 32'h00FF);
        wb_read(4'd0, rd);
        check("rd_out", {16'b0, rd}, 32'hA5A5);
        wb_read(4'd2, rd);
        check("rd_dir", {16'b0, rd}, 32'h00FF);

        // Asynchronous reset in the middle of a cycle.
        #2 rst = 1'b1;
        #1;
        check("async_gpio_o",  {16'b0, gpio_o},   32'h0);
        check("async_gpio_oe", {16'b0, gpio_oe},  32'h0);
        check("async_dat",     {16'b0, wb_dat_o}, 32'h0);
        check("async_ack",     {31'b0, wb_ack_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);

        // Synchroniser latency and unmapped read.
        gpio_i = 16'h0003;
        wb_read(4'd1, rd);
        check("in_before_sync", {16'b0, rd}, 32'h0000);
        wb_read(4'd1, rd);
        check("in_after_sync", {16'b0, rd}, 32'h0003);
        wb_read(4'hC, rd);
        check("rd_unmapped", {16'b0, rd}, 32'h0000);
        gpio_i = 16'h0000;
        tick(4);

        // Rising edge capture raises STATUS and irq.
        wb_write(4'd3, 16'h0001);
        wb_write(4'd6, 16'h0001);
        gpio_i = 16'h0001;
        tick(5);
        wb_read(4'd5, rd);
        check("status_rise", {16'b0, rd}, 32'h0001);
        check("irq_rise", {31'b0, irq_o}, 32'h1);

        // Falling edge with FALL_EN=0 leaves STATUS alone.
        gpio_i = 16'h0000;
        tick(5);
        wb_read(4'd5, rd);
        check("status_nofall", {16'b0, rd}, 32'h0001);

        // W1C colliding with a new rising edge on the same pin.
        gpio_i = 16'h0001;
        tick(2);
        wb_write(4'd5, 16'h0001);
        wb_read(4'd5, rd);
        check("status_collide", {16'b0, rd}, 32'h0001);
        check("irq_collide", {31'b0, irq_o}, 32'h1);

        // Clean W1C.
        wb_write(4'd5, 16'h0001);
        wb_read(4'd5, rd);
        check("status_cleared", {16'b0, rd}, 32'h0000);
        check("irq_cleared", {31'b0, irq_o}, 32'h0);

        // Mask gating.
        wb_write(4'd6, 16'h0000);
        wb_write(4'd3, 16'h0002);
        gpio_i = 16'h0003;
        tick(5);
        wb_read(4'd5, rd);
        check("status_pin1", {16'b0, rd}, 32'h0002);
        check("irq_masked", {31'b0, irq_o}, 32'h0);
        wb_write(4'd6, 16'h0002);
        check("irq_at_ack", {31'b0, irq_o}, 32'h0);
        tick(1);
        check("irq_unmasked", {31'b0, irq_o}, 32'h1);

        // Atomic aliases (or their absence).
        wb_write(4'd0, 16'h00F0);
        wb_write(4'd7, 16'h000F);
        wb_read(4'd0, rd);
`ifdef WB_GPIO_ATOMIC_EN
        check("atomic_set", {16'b0, rd}, 32'h00FF);
`else
        check("atomic_set", {16'b0, rd}, 32'h00F0);
`endif
        wb_write(4'd8, 16'h0030);
        wb_read(4'd0, rd);
`ifdef WB_GPIO_ATOMIC_EN
        check("atomic_clr", {16'b0, rd}, 32'h00CF);
`else
        check("atomic_clr", {16'b0, rd}, 32'h00F0);
`endif
        wb_write(4'd9, 16'hFFFF);
        wb_read(4'd0, rd);
`ifdef WB_GPIO_ATOMIC_EN
        check("atomic_tgl", {16'b0, rd}, 32'hFF30);
`else
        check("atomic_tgl", {16'b0, rd}, 32'h00F0);
`endif
        wb_read(4'd7, rd);
        check("rd_set_addr", {16'b0, rd}, 32'h0000);

        // Sustained strobe: one access every two cycles.
        acks     = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 4'd1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check("throughput_acks", acks, 32'd3);
        tick(1);

        // Reset during an acknowledged write: ack and the write are lost.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 4'd0;
        wb_dat_i = 16'h1234;
        @(posedge clk);
        #1;
        check("mid_ack", {31'b0, wb_ack_o}, 32'h1);
        #2 rst = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        #1;
        check("mid_ack_drop", {31'b0, wb_ack_o}, 32'h0);
        check("mid_gpio_o", {16'b0, gpio_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        wb_read(4'd0, rd);
        check("mid_out_lost", {16'b0, rd}, 32'h0000);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
